// File: rtl/ws2812_rx.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_rx
// Function : WS2812 single-wire receiver; captures the first NBITS bits of a
//            frame as the pixel word and forwards the rest on dout.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_rx #(
    parameter int CHANNELS      = 3,
    parameter int BITPERCHANNEL = 8,
    parameter int MIN_HIGH      = 3,
    parameter int BIT_THRESH    = 15,
    parameter int HIGH_MAX      = 62,
    parameter int RESET_CYCLES  = 1250
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                din,
    output logic                                dout,
    output logic [CHANNELS*BITPERCHANNEL-1:0]   data_o,
    output logic                                data_valid,
    output logic                                bit_error
);

    localparam int NBITS = CHANNELS * BITPERCHANNEL;
    localparam int HW    = $clog2(HIGH_MAX + 1);
    localparam int LW    = $clog2(RESET_CYCLES + 1);
    localparam int BW    = $clog2(NBITS + 1);

    localparam logic [HW-1:0] c_MIN_HIGH   = HW'(MIN_HIGH);
    localparam logic [HW-1:0] c_BIT_THRESH = HW'(BIT_THRESH);
    localparam logic [HW-1:0] c_HIGH_MAX   = HW'(HIGH_MAX);
    localparam logic [LW-1:0] c_RESET_MAX  = LW'(RESET_CYCLES);
    localparam logic [LW-1:0] c_GAP_LAST   = LW'(RESET_CYCLES - 1);
    localparam logic [BW-1:0] c_LAST_BIT   = BW'(NBITS - 1);

    logic             r_sync;
    logic             r_din_s;
    logic             r_din_d;
    logic [HW-1:0]    r_hcnt;
    logic [LW-1:0]    r_lcnt;
    logic [BW-1:0]    r_bitcnt;
    logic             r_full;
    logic [NBITS-1:0] r_shreg;

    logic             w_fall;
    logic             w_h_bad;
    logic             w_bit;
    logic             w_gap;

    always_comb begin
        w_fall  = r_din_d & ~r_din_s;
        w_h_bad = (r_hcnt < c_MIN_HIGH) || (r_hcnt >= c_HIGH_MAX);
        w_bit   = (r_hcnt >= c_BIT_THRESH);
        // Fires only on the cycle lcnt steps onto its saturation value
        w_gap   = ~r_din_s && (r_lcnt == c_GAP_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= 1'b0;
            r_din_s    <= 1'b0;
            r_din_d    <= 1'b0;
            r_hcnt     <= '0;
            r_lcnt     <= '0;
            r_bitcnt   <= '0;
            r_full     <= 1'b0;
            r_shreg    <= '0;
            dout       <= 1'b0;
            data_o     <= '0;
            data_valid <= 1'b0;
            bit_error  <= 1'b0;
        end else begin
            r_sync     <= din;
            r_din_s    <= r_sync;
            r_din_d    <= r_din_s;
            data_valid <= 1'b0;
            bit_error  <= 1'b0;
            dout       <= r_full & r_din_s;

            if (r_din_s) begin
                r_lcnt <= '0;
                if (r_hcnt != c_HIGH_MAX) r_hcnt <= r_hcnt + HW'(1);
            end else begin
                r_hcnt <= '0;
                if (r_lcnt != c_RESET_MAX) r_lcnt <= r_lcnt + LW'(1);
            end

            if (w_gap) begin
                if (r_full) begin
                    data_o     <= r_shreg;
                    data_valid <= 1'b1;
                end else if (r_bitcnt != '0) begin
                    bit_error  <= 1'b1;
                end
                r_bitcnt <= '0;
                r_full   <= 1'b0;
            end else if (w_fall && !r_full) begin
                if (w_h_bad) begin
                    bit_error <= 1'b1;
                end else begin
                    r_shreg  <= {r_shreg[NBITS-2:0], w_bit};
                    r_bitcnt <= r_bitcnt + BW'(1);
                    if (r_bitcnt == c_LAST_BIT) r_full <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_rx
// Function : Directed plus randomized checks of ws2812_rx against a
//            bit-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic        dout;
    logic [23:0] data_o;
    logic        data_valid;
    logic        bit_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   n_valid = 0;
    int   n_err = 0;
    int   dout_run = 0;
    logic dout_prev = 1'b0;
    int   dout_widths[$];
    int   dout_rises[$];

    ws2812_rx dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .dout       (dout),
        .data_o     (data_o),
        .data_valid (data_valid),
        .bit_error  (bit_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) n_valid = n_valid + 1;
        if (bit_error) n_err = n_err + 1;
        if (dout) begin
            dout_run = dout_run + 1;
            if (!dout_prev) dout_rises.push_back(cyc);
        end else if (dout_prev) begin
            dout_widths.push_back(dout_run);
            dout_run = 0;
        end
        dout_prev = dout;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input int h, input int lo, output int rise);
        din  = 1'b1;
        rise = cyc;
        tick(h);
        din  = 1'b0;
        tick(lo);
    endtask

    task automatic send_word(input logic [23:0] w, input int hz, input int ho, input int period);
        int r;
        for (int i = 23; i >= 0; i--) begin
            send_bit(w[i] ? ho : hz, period - (w[i] ? ho : hz), r);
        end
    endtask

    function automatic int rand_h(input logic b);
        return b ? int'($urandom_range(61, 15)) : int'($urandom_range(14, 3));
    endfunction

    int          v0, e0, w0, r0, rise, h;
    logic [23:0] word, word_b, last_word;
    int          exp_w[$];
    int          stuck_at, extra, n_stuck;

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        tick(5);
        reset = 1'b0;
        tick(1);
        check("reset_data_o", 32'(data_o), 32'h0);
        check("reset_valid", 32'(data_valid), 32'h0);
        check("reset_err", 32'(bit_error), 32'h0);
        check("reset_dout", 32'(dout), 32'h0);

        // single frame, nothing forwarded
        v0 = n_valid; e0 = n_err; r0 = dout_rises.size();
        send_word(24'hA53CF0, 10, 20, 31);
        tick(1300);
        check("t1_data", 32'(data_o), 32'hA53CF0);
        check("t1_valid", n_valid - v0, 1);
        check("t1_err", n_err - e0, 0);
        check("t1_dout", dout_rises.size() - r0, 0);

        // two pixels: second one must be forwarded intact
        word_b = 24'hFFFF00;
        v0 = n_valid; e0 = n_err; w0 = dout_widths.size(); r0 = dout_rises.size();
        send_word(24'h123456, 10, 20, 31);
        for (int i = 23; i >= 0; i--) begin
            h = word_b[i] ? 20 : 10;
            if (i == 23) send_bit(h, 31 - h, rise);
            else send_bit(h, 31 - h, r0);
        end
        tick(1300);
        check("t2_data", 32'(data_o), 32'h123456);
        check("t2_valid", n_valid - v0, 1);
        check("t2_nwidths", dout_widths.size() - w0, 24);
        for (int i = 0; i < 24; i++) begin
            if (w0 + i < dout_widths.size())
                check("t2_width", dout_widths[w0 + i], word_b[23 - i] ? 20 : 10);
        end
        if (w0 < dout_rises.size()) check("t2_delay", dout_rises[w0] - rise, 3);
        else check("t2_delay_missing", dout_rises.size(), w0 + 1);

        // threshold boundary 14 -> 0, 15 -> 1
        v0 = n_valid;
        send_word(24'h555555, 14, 15, 31);
        tick(1300);
        check("t3_data", 32'(data_o), 32'h555555);
        check("t3_valid", n_valid - v0, 1);

        // glitch mid-frame is dropped
        word = 24'($urandom);
        v0 = n_valid; e0 = n_err;
        for (int i = 23; i >= 0; i--) begin
            if (i == 11) send_bit(2, 10, r0);
            h = word[i] ? 20 : 10;
            send_bit(h, 31 - h, r0);
        end
        tick(1300);
        check("t4_data", 32'(data_o), 32'(word));
        check("t4_err", n_err - e0, 1);
        check("t4_valid", n_valid - v0, 1);
        last_word = word;

        // partial frame discarded
        v0 = n_valid; e0 = n_err;
        for (int i = 0; i < 10; i++) send_bit(20, 11, r0);
        tick(1300);
        check("t5_err", n_err - e0, 1);
        check("t5_valid", n_valid - v0, 0);
        check("t5_data", 32'(data_o), 32'(last_word));

        // reset mid-frame, then a frame with a 1249-cycle in-frame low
        for (int i = 0; i < 12; i++) send_bit(10, 21, r0);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        v0 = n_valid; e0 = n_err;
        word = 24'h00FF0F;
        for (int i = 23; i >= 0; i--) begin
            h = word[i] ? 20 : 10;
            send_bit(h, (i == 16) ? 1249 : 31 - h, r0);
        end
        tick(1300);
        check("t6_data", 32'(data_o), 32'h00FF0F);
        check("t6_valid", n_valid - v0, 1);
        check("t6_err", n_err - e0, 0);

        // randomized frames: random widths, stuck-high pulses, forwarded tails
        for (int f = 0; f < 6; f++) begin
            word     = 24'($urandom);
            stuck_at = ($urandom % 2 == 0) ? int'($urandom_range(23, 0)) : -1;
            extra    = int'($urandom_range(6, 0));
            n_stuck  = 0;
            exp_w.delete();
            v0 = n_valid; e0 = n_err; w0 = dout_widths.size();
            for (int i = 23; i >= 0; i--) begin
                if (i == stuck_at) begin
                    send_bit(int'($urandom_range(75, 62)), int'($urandom_range(40, 1)), r0);
                    n_stuck++;
                end
                send_bit(rand_h(word[i]), int'($urandom_range(40, 1)), r0);
            end
            for (int k = 0; k < extra; k++) begin
                h = rand_h(1'($urandom));
                exp_w.push_back(h);
                send_bit(h, int'($urandom_range(40, 4)), r0);
            end
            tick(1300);
            check("rnd_data", 32'(data_o), 32'(word));
            check("rnd_valid", n_valid - v0, 1);
            check("rnd_err", n_err - e0, n_stuck);
            check("rnd_nwidths", dout_widths.size() - w0, extra);
            for (int k = 0; k < extra; k++) begin
                if (w0 + k < dout_widths.size())
                    check("rnd_width", dout_widths[w0 + k], exp_w[k]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
